mem_arbiter: RTL and testbench
==============================

// Module: mem_arbiter
// PURPOSE
//  Shares the single DPI-backed data memory port between IFU (read-only) and LSU (read/write).
//  Round-robin arbitration; one access in flight; configurable access LATENCY for multi-cycle NPC.
//  Sits between IFU/LSU and the memory wrapper; memory must act only when mem_valid=1.
// PARAMETERS
//  LATENCY  1   cycles from request accept to memory access cycle; legal 1..255 (8-bit counter)
// PORTS
//  clock           in   1   system clock
//  reset           in   1   synchronous reset, active-low (0 = reset)
//  ifu_req_valid   in   1   IFU read request
//  ifu_req_ready   out  1   IFU request accepted this cycle when valid&ready
//  ifu_addr        in   32  IFU read address
//  ifu_resp_valid  out  1   one-cycle pulse: ifu_rdata valid
//  ifu_rdata       out  32  IFU read data
//  lsu_req_valid   in   1   LSU request
//  lsu_req_ready   out  1   LSU request accepted this cycle when valid&ready
//  lsu_addr        in   32  LSU address
//  lsu_wen         in   1   1 = write, 0 = read
//  lsu_wdata       in   32  LSU write data
//  lsu_wmask       in   8   LSU byte write mask
//  lsu_resp_valid  out  1   one-cycle pulse: LSU access complete (lsu_rdata valid for reads)
//  lsu_rdata       out  32  LSU read data; 0 for writes
//  mem_valid       out  1   memory performs access this cycle
//  mem_addr        out  32  latched request address
//  mem_wdata       out  32  latched write data
//  mem_wmask       out  8   latched write mask (0 for IFU)
//  mem_memRW       out  1   1 = write; only 1 when mem_valid=1 and latched wen=1
//  mem_rdata       in   32  memory read data, combinational, sampled in ACCESS cycle
// BEHAVIOUR
//  States: IDLE, WAIT, ACCESS, RESP. Reset: IDLE; all outputs/registers 0; last_grant=IFU.
//  IDLE: ready asserted combinationally only to the arbitration winner among valid requesters.
//   Only one valid -> it wins. Both valid -> the one NOT in last_grant wins (first tie -> LSU).
//   No valid -> both ready=0, stay IDLE.
//  Accept (valid&ready in IDLE, cycle T): latch addr/wdata/wmask/wen/owner, last_grant<=owner.
//   IFU accept latches wen=0, wmask=0, wdata=0. Inputs ignored outside accept cycle.
//  T -> WAIT if LATENCY>1 (count LATENCY-1 cycles), else directly ACCESS.
//  ACCESS (cycle T+LATENCY): mem_valid=1 exactly one cycle; mem_rdata captured if read.
//  RESP (cycle T+LATENCY+1): owner resp_valid=1 one cycle with rdata; other resp_valid=0.
//   -> IDLE; next accept earliest at T+LATENCY+2. ready=0 in WAIT/ACCESS/RESP.
//  No response backpressure: requesters must take resp in the RESP cycle.
//  rdata outputs hold last captured value until next capture; lsu_rdata=0 after LSU write.
//  mem_addr/wdata/wmask hold latched values between accesses; mem_valid/mem_memRW 0 outside ACCESS.
//  Reset mid-operation: state->IDLE next edge; no mem_valid or resp_valid for abandoned request.
//  A write is issued to memory exactly once per accepted LSU write (DPI side effects).
// TESTING
//  LATENCY=1, IFU read 0x80000000, mem_rdata=0x00000413 -> mem_valid@T+1, ifu_resp_valid@T+2, ifu_rdata=0x00000413.
//  LSU write 0x80001000, wdata=0xDEADBEEF, wmask=0x0F -> one mem_valid cycle with memRW=1, lsu_resp_valid, lsu_rdata=0.
//  Both valid from reset, held continuously -> grants LSU, IFU, LSU, IFU; no double grant.
//  LATENCY=4, LSU read -> mem_valid exactly at T+4, lsu_resp_valid at T+5, ready=0 T+1..T+5.
//  Reset low during WAIT of LSU write -> no mem_valid, no resp; IDLE, outputs 0 next cycle.
//  Requester drops valid while in WAIT -> access still completes from latched values.

Source files
------------

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one memory port between IFU (read-only) and LSU (read/write).
// One access in flight; the memory access cycle comes LATENCY cycles after the request is accepted.
module mem_arbiter #(
    parameter int LATENCY = 1
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        ifu_req_valid,
    output logic        ifu_req_ready,
    input  logic [31:0] ifu_addr,
    output logic        ifu_resp_valid,
    output logic [31:0] ifu_rdata,
    input  logic        lsu_req_valid,
    output logic        lsu_req_ready,
    input  logic [31:0] lsu_addr,
    input  logic        lsu_wen,
    input  logic [31:0] lsu_wdata,
    input  logic [7:0]  lsu_wmask,
    output logic        lsu_resp_valid,
    output logic [31:0] lsu_rdata,
    output logic        mem_valid,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [7:0]  mem_wmask,
    output logic        mem_memRW,
    input  logic [31:0] mem_rdata
);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_WAIT   = 2'd1;
    localparam logic [1:0] S_ACCESS = 2'd2;
    localparam logic [1:0] S_RESP   = 2'd3;

    // WAIT spans LATENCY-1 cycles, so the counter starts at LATENCY-2 and exits at zero.
    localparam logic [7:0] WAIT_INIT = (LATENCY > 1) ? 8'(LATENCY - 2) : 8'd0;

    logic [1:0]  state;
    logic [7:0]  cnt;
    logic        owner;       // 1 = LSU
    logic        last_grant;  // 1 = LSU
    logic        lat_wen;
    logic [31:0] lat_addr;
    logic [31:0] lat_wdata;
    logic [7:0]  lat_wmask;
    logic        grant_ifu;
    logic        grant_lsu;

    // Ready is held off while reset is low so no handshake is seen that the registers ignore.
    always_comb begin
        grant_ifu = 1'b0;
        grant_lsu = 1'b0;
        if (state == S_IDLE && reset) begin
            grant_lsu = lsu_req_valid && (!ifu_req_valid || !last_grant);
            grant_ifu = ifu_req_valid && (!lsu_req_valid || last_grant);
        end
    end

    assign ifu_req_ready  = grant_ifu;
    assign lsu_req_ready  = grant_lsu;
    assign mem_valid      = (state == S_ACCESS);
    assign mem_memRW      = mem_valid && lat_wen;
    assign mem_addr       = lat_addr;
    assign mem_wdata      = lat_wdata;
    assign mem_wmask      = lat_wmask;
    assign ifu_resp_valid = (state == S_RESP) && !owner;
    assign lsu_resp_valid = (state == S_RESP) && owner;

    always_ff @(posedge clock) begin
        if (!reset) begin
            state      <= S_IDLE;
            cnt        <= '0;
            owner      <= 1'b0;
            last_grant <= 1'b0;
            lat_wen    <= 1'b0;
            lat_addr   <= '0;
            lat_wdata  <= '0;
            lat_wmask  <= '0;
            ifu_rdata  <= '0;
            lsu_rdata  <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (grant_ifu || grant_lsu) begin
                        owner      <= grant_lsu;
                        last_grant <= grant_lsu;
                        lat_addr   <= grant_lsu ? lsu_addr : ifu_addr;
                        lat_wen    <= grant_lsu && lsu_wen;
                        lat_wdata  <= grant_lsu ? lsu_wdata : '0;
                        lat_wmask  <= grant_lsu ? lsu_wmask : '0;
                        cnt        <= WAIT_INIT;
                        state      <= (LATENCY > 1) ? S_WAIT : S_ACCESS;
                    end
                end
                S_WAIT: begin
                    if (cnt == 8'd0) state <= S_ACCESS;
                    else             cnt   <= cnt - 8'd1;
                end
                S_ACCESS: begin
                    if (owner) lsu_rdata <= lat_wen ? '0 : mem_rdata;
                    else       ifu_rdata <= mem_rdata;
                    state <= S_RESP;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: instances with LATENCY=1 and LATENCY=4 checked every cycle
// against a transaction-timing reference model, plus directed scenario checks.
module tb_mem_arbiter;

    logic        clock = 1'b0;
    always #5 clock = ~clock;

    logic        rst_n    [2];
    logic        ifu_v    [2];
    logic        ifu_rr   [2];
    logic [31:0] ifu_a    [2];
    logic        ifu_rv   [2];
    logic [31:0] ifu_rd   [2];
    logic        lsu_v    [2];
    logic        lsu_rr   [2];
    logic [31:0] lsu_a    [2];
    logic        lsu_we   [2];
    logic [31:0] lsu_wd   [2];
    logic [7:0]  lsu_wm   [2];
    logic        lsu_rv   [2];
    logic [31:0] lsu_rd   [2];
    logic        m_valid  [2];
    logic [31:0] m_addr   [2];
    logic [31:0] m_wdata  [2];
    logic [7:0]  m_wmask  [2];
    logic        m_rw     [2];
    logic [31:0] m_rdata  [2];

    for (genvar g = 0; g < 2; g++) begin : g_dut
        mem_arbiter #(.LATENCY(g == 0 ? 1 : 4)) u_dut (
            .clock          (clock),
            .reset          (rst_n[g]),
            .ifu_req_valid  (ifu_v[g]),
            .ifu_req_ready  (ifu_rr[g]),
            .ifu_addr       (ifu_a[g]),
            .ifu_resp_valid (ifu_rv[g]),
            .ifu_rdata      (ifu_rd[g]),
            .lsu_req_valid  (lsu_v[g]),
            .lsu_req_ready  (lsu_rr[g]),
            .lsu_addr       (lsu_a[g]),
            .lsu_wen        (lsu_we[g]),
            .lsu_wdata      (lsu_wd[g]),
            .lsu_wmask      (lsu_wm[g]),
            .lsu_resp_valid (lsu_rv[g]),
            .lsu_rdata      (lsu_rd[g]),
            .mem_valid      (m_valid[g]),
            .mem_addr       (m_addr[g]),
            .mem_wdata      (m_wdata[g]),
            .mem_wmask      (m_wmask[g]),
            .mem_memRW      (m_rw[g]),
            .mem_rdata      (m_rdata[g])
        );
    end

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    // Reference model: one pending transaction described by its accept cycle.
    int          lat     [2] = '{1, 4};
    bit          busy    [2];
    int          acc_cyc [2];
    bit          t_lsu   [2];
    bit          t_wen   [2];
    logic [31:0] t_addr  [2];
    logic [31:0] t_wdata [2];
    logic [7:0]  t_wmask [2];
    bit          lastg   [2];
    logic [31:0] e_ird   [2];
    logic [31:0] e_lrd   [2];

    bit recording = 1'b0;
    bit grants[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset(input int d);
        busy[d]    = 1'b0;
        lastg[d]   = 1'b0;
        t_lsu[d]   = 1'b0;
        t_wen[d]   = 1'b0;
        t_addr[d]  = '0;
        t_wdata[d] = '0;
        t_wmask[d] = '0;
        e_ird[d]   = '0;
        e_lrd[d]   = '0;
    endtask

    task automatic idle_inputs(input int d);
        rst_n[d]   = 1'b1;
        ifu_v[d]   = 1'b0;
        ifu_a[d]   = '0;
        lsu_v[d]   = 1'b0;
        lsu_a[d]   = '0;
        lsu_we[d]  = 1'b0;
        lsu_wd[d]  = '0;
        lsu_wm[d]  = '0;
        m_rdata[d] = '0;
    endtask

    // Check every output of both instances for the current cycle, then advance the model.
    task automatic eval();
        #1;
        for (int d = 0; d < 2; d++) begin
            int   ph;
            bit   idle, e_mv, e_ir, e_lr, win_lsu;
            string s;
            ph   = cyc - acc_cyc[d];
            idle = !busy[d];
            e_mv = busy[d] && (ph == lat[d]);
            if (ifu_v[d] && lsu_v[d]) win_lsu = !lastg[d];
            else                      win_lsu = lsu_v[d];
            e_ir = idle && rst_n[d] && ifu_v[d] && !win_lsu;
            e_lr = idle && rst_n[d] && lsu_v[d] && win_lsu;
            s = $sformatf("L%0d@%0d", lat[d], cyc);
            chk({s, " ifu_req_ready"},  32'(ifu_rr[d]),  32'(e_ir));
            chk({s, " lsu_req_ready"},  32'(lsu_rr[d]),  32'(e_lr));
            chk({s, " mem_valid"},      32'(m_valid[d]), 32'(e_mv));
            chk({s, " mem_memRW"},      32'(m_rw[d]),    32'(e_mv && t_wen[d]));
            chk({s, " ifu_resp_valid"}, 32'(ifu_rv[d]),  32'(busy[d] && ph == lat[d] + 1 && !t_lsu[d]));
            chk({s, " lsu_resp_valid"}, 32'(lsu_rv[d]),  32'(busy[d] && ph == lat[d] + 1 && t_lsu[d]));
            chk({s, " mem_addr"},       m_addr[d],       t_addr[d]);
            chk({s, " mem_wdata"},      m_wdata[d],      t_wdata[d]);
            chk({s, " mem_wmask"},      32'(m_wmask[d]), 32'(t_wmask[d]));
            chk({s, " ifu_rdata"},      ifu_rd[d],       e_ird[d]);
            chk({s, " lsu_rdata"},      lsu_rd[d],       e_lrd[d]);
            if (recording && d == 0) begin
                if (ifu_v[0] && ifu_rr[0]) grants.push_back(1'b0);
                if (lsu_v[0] && lsu_rr[0]) grants.push_back(1'b1);
            end
            if (!rst_n[d]) begin
                model_reset(d);
            end else begin
                if (e_mv) begin
                    if (t_lsu[d]) e_lrd[d] = t_wen[d] ? 32'h0 : m_rdata[d];
                    else          e_ird[d] = m_rdata[d];
                end
                if (busy[d] && ph == lat[d] + 1) begin
                    busy[d] = 1'b0;
                end else if (e_ir || e_lr) begin
                    busy[d]    = 1'b1;
                    acc_cyc[d] = cyc;
                    t_lsu[d]   = e_lr;
                    lastg[d]   = e_lr;
                    t_addr[d]  = e_lr ? lsu_a[d] : ifu_a[d];
                    t_wen[d]   = e_lr && lsu_we[d];
                    t_wdata[d] = e_lr ? lsu_wd[d] : 32'h0;
                    t_wmask[d] = e_lr ? lsu_wm[d] : 8'h0;
                end
            end
        end
        cyc++;
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic cycle();
        eval();
        tick();
    endtask

    initial begin
        for (int d = 0; d < 2; d++) begin
            idle_inputs(d);
            rst_n[d] = 1'b0;
        end
        tick();
        tick();
        for (int d = 0; d < 2; d++) begin
            model_reset(d);
            rst_n[d] = 1'b1;
        end

        // Reset state
        eval();
        chk("reset mem_addr", m_addr[0], 32'h0);
        chk("reset ifu_rdata", ifu_rd[0], 32'h0);
        tick();

        // IFU read, LATENCY=1
        ifu_v[0] = 1'b1;
        ifu_a[0] = 32'h8000_0000;
        eval();
        chk("ifu accept ready", 32'(ifu_rr[0]), 32'd1);
        tick();
        ifu_v[0]   = 1'b0;
        m_rdata[0] = 32'h0000_0413;
        eval();
        chk("ifu T+1 mem_valid", 32'(m_valid[0]), 32'd1);
        chk("ifu T+1 mem_addr", m_addr[0], 32'h8000_0000);
        tick();
        m_rdata[0] = 32'h0;
        eval();
        chk("ifu T+2 resp_valid", 32'(ifu_rv[0]), 32'd1);
        chk("ifu T+2 rdata", ifu_rd[0], 32'h0000_0413);
        tick();

        // LSU write, LATENCY=1
        lsu_v[0]  = 1'b1;
        lsu_we[0] = 1'b1;
        lsu_a[0]  = 32'h8000_1000;
        lsu_wd[0] = 32'hDEAD_BEEF;
        lsu_wm[0] = 8'h0F;
        cycle();
        lsu_v[0] = 1'b0;
        eval();
        chk("lsu wr mem_valid", 32'(m_valid[0]), 32'd1);
        chk("lsu wr memRW", 32'(m_rw[0]), 32'd1);
        chk("lsu wr wdata", m_wdata[0], 32'hDEAD_BEEF);
        chk("lsu wr wmask", 32'(m_wmask[0]), 32'h0F);
        tick();
        eval();
        chk("lsu wr resp_valid", 32'(lsu_rv[0]), 32'd1);
        chk("lsu wr rdata", lsu_rd[0], 32'h0);
        tick();
        idle_inputs(0);

        // Both requesters held valid from reset: strict alternation starting with LSU
        rst_n[0] = 1'b0;
        cycle();
        rst_n[0]  = 1'b1;
        ifu_v[0]  = 1'b1;
        ifu_a[0]  = 32'h8000_0100;
        lsu_v[0]  = 1'b1;
        lsu_a[0]  = 32'h8000_2000;
        recording = 1'b1;
        for (int i = 0; i < 12; i++) cycle();
        recording = 1'b0;
        idle_inputs(0);
        chk("tie grant count", 32'(grants.size()), 32'd4);
        for (int i = 0; i < 4 && i < grants.size(); i++)
            chk($sformatf("tie grant %0d", i), 32'(grants[i]), (i % 2 == 0) ? 32'd1 : 32'd0);

        // LSU read, LATENCY=4, valid held through the transaction
        lsu_v[1]   = 1'b1;
        lsu_a[1]   = 32'h8000_3000;
        m_rdata[1] = 32'hCAFE_F00D;
        eval();
        chk("L4 accept ready", 32'(lsu_rr[1]), 32'd1);
        tick();
        for (int k = 1; k <= 5; k++) begin
            eval();
            chk($sformatf("L4 T+%0d ready", k), 32'(lsu_rr[1]), 32'd0);
            chk($sformatf("L4 T+%0d mem_valid", k), 32'(m_valid[1]), (k == 4) ? 32'd1 : 32'd0);
            chk($sformatf("L4 T+%0d resp_valid", k), 32'(lsu_rv[1]), (k == 5) ? 32'd1 : 32'd0);
            tick();
        end
        chk("L4 lsu_rdata", lsu_rd[1], 32'hCAFE_F00D);
        idle_inputs(1);
        for (int i = 0; i < 6; i++) cycle();

        // Reset while an LSU write waits: nothing reaches memory
        lsu_v[1]  = 1'b1;
        lsu_we[1] = 1'b1;
        lsu_a[1]  = 32'h8000_4000;
        lsu_wd[1] = 32'h1234_5678;
        lsu_wm[1] = 8'hFF;
        cycle();
        lsu_v[1] = 1'b0;
        cycle();
        rst_n[1] = 1'b0;
        cycle();
        rst_n[1] = 1'b1;
        for (int i = 0; i < 6; i++) begin
            eval();
            chk("rst-wait mem_valid", 32'(m_valid[1]), 32'd0);
            chk("rst-wait resp", 32'(lsu_rv[1]), 32'd0);
            chk("rst-wait mem_addr", m_addr[1], 32'h0);
            tick();
        end

        // IFU drops valid during WAIT; access still completes from latched address
        ifu_v[1] = 1'b1;
        ifu_a[1] = 32'h8000_5004;
        cycle();
        ifu_v[1]   = 1'b0;
        ifu_a[1]   = 32'h0BAD_0BAD;
        m_rdata[1] = 32'h0000_0073;
        for (int k = 1; k <= 5; k++) begin
            eval();
            if (k == 4) chk("drop mem_addr", m_addr[1], 32'h8000_5004);
            if (k == 5) chk("drop ifu_resp", 32'(ifu_rv[1]), 32'd1);
            tick();
        end
        chk("drop ifu_rdata", ifu_rd[1], 32'h0000_0073);
        idle_inputs(1);

        // Randomized traffic on both instances, occasional reset
        for (int n = 0; n < 1500; n++) begin
            for (int d = 0; d < 2; d++) begin
                rst_n[d]   = ($urandom_range(0, 79) != 0);
                ifu_v[d]   = ($urandom_range(0, 2) != 0);
                ifu_a[d]   = $urandom;
                lsu_v[d]   = ($urandom_range(0, 2) != 0);
                lsu_a[d]   = $urandom;
                lsu_we[d]  = $urandom_range(0, 1) == 1;
                lsu_wd[d]  = $urandom;
                lsu_wm[d]  = 8'($urandom);
                m_rdata[d] = $urandom;
            end
            cycle();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
